// File: rtl/sdm_adc.sv
// Sigma-delta bitstream decimator: sinc^ORDER CIC filter with integrators at the bit rate,
// combs at the frame rate, then an arithmetic rescale and saturation to OUT_W-bit PCM.
module sdm_adc #(
    parameter int ORDER = 3,
    parameter int DECIM = 64,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic                    din,
    output logic                    valid_out,
    output logic signed [OUT_W-1:0] dout
);

    localparam int LR    = $clog2(DECIM);
    localparam int ACC_W = ORDER * LR + 2;
    localparam int SHIFT = ORDER * LR + 1 - OUT_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    if (ORDER < 1 || ORDER > 5) begin : g_bad_order
        $error("sdm_adc: ORDER must be in 1..5");
    end
    if (DECIM < 2 || DECIM > 256 || (DECIM & (DECIM - 1)) != 0) begin : g_bad_decim
        $error("sdm_adc: DECIM must be a power of two in 2..256");
    end
    if (SHIFT < 0) begin : g_bad_shift
        $error("sdm_adc: OUT_W too wide for ORDER and DECIM");
    end

    logic signed [ACC_W-1:0] x_val;
    logic        [LR-1:0]    count;
    logic                    last_sample;
    logic                    frame_done;
    logic signed [ACC_W-1:0] comb_in;
    logic signed [ACC_W-1:0] comb_out;
    logic signed [ACC_W-1:0] scaled;
    logic signed [OUT_W-1:0] sat_val;

    assign x_val       = din ? ACC_W'(1) : {ACC_W{1'b1}};
    assign last_sample = valid_in && (count == LR'(DECIM - 1));

    // Integrator chain; every stage updates in parallel from pre-edge values and wraps freely.
    for (genvar g = 0; g < ORDER; g++) begin : g_int
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] addend;
        logic signed [ACC_W-1:0] nxt;

        if (g == 0) begin : g_src
            assign addend = x_val;
        end else begin : g_src
            assign addend = g_int[g-1].acc;
        end

        assign nxt = acc + addend;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc <= '0;
            end else if (valid_in) begin
                acc <= nxt;
            end
        end
    end

    // The frame's final integrator value is latched so the combs run on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            frame_done <= 1'b0;
            comb_in    <= '0;
        end else begin
            frame_done <= last_sample;
            if (valid_in) begin
                count <= count + LR'(1);
            end
            if (last_sample) begin
                comb_in <= g_int[ORDER-1].nxt;
            end
        end
    end

    // Comb chain, one delay register per stage, advanced once per frame.
    for (genvar g = 0; g < ORDER; g++) begin : g_comb
        logic signed [ACC_W-1:0] u;
        logic signed [ACC_W-1:0] y;
        logic signed [ACC_W-1:0] dly;

        if (g == 0) begin : g_src
            assign u = comb_in;
        end else begin : g_src
            assign u = g_comb[g-1].y;
        end

        assign y = u - dly;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dly <= '0;
            end else if (frame_done) begin
                dly <= u;
            end
        end
    end

    assign comb_out = g_comb[ORDER-1].y;
    assign scaled   = comb_out >>> SHIFT;

    // Only an all-ones frame can exceed the positive limit; the negative limit is exact.
    always_comb begin
        sat_val = scaled[OUT_W-1:0];
        if (scaled > SAT_MAX) begin
            sat_val = SAT_MAX[OUT_W-1:0];
        end else if (scaled < SAT_MIN) begin
            sat_val = SAT_MIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            dout      <= '0;
        end else begin
            valid_out <= frame_done;
            if (frame_done) begin
                dout <= sat_val;
            end
        end
    end

endmodule

// File: tb/tb_sdm_adc.sv
// Directed bench for sdm_adc: steady-state PCM values for fixed bit patterns, strobe timing
// against a count of accepted samples, valid_in gaps, and asynchronous reset behaviour.
`timescale 1ns/100ps
module tb_sdm_adc;

    localparam int ORDER = 3;
    localparam int DECIM = 64;
    localparam int OUT_W = 16;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    valid_in;
    logic                    din;
    logic                    valid_out;
    logic signed [OUT_W-1:0] dout;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int strobe_cnt = 0;
    bit pend = 1'b0;

    sdm_adc #(.ORDER(ORDER), .DECIM(DECIM), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .din       (din),
        .valid_out (valid_out),
        .dout      (dout)
    );

    always #177.3 clk = ~clk;

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n    = 1'b0;
        valid_in = 1'b0;
        din      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        acc_cnt    = 0;
        strobe_cnt = 0;
        pend       = 1'b0;
    endtask

    // One clock of stimulus; a strobe is due exactly one edge after every DECIM-th accepted sample.
    task automatic applyStimulus(input bit b, input bit v, input int exp_val);
        @(negedge clk);
        din      = b;
        valid_in = v;
        @(posedge clk);
        #1;
        checkOutput("valid_out", valid_out, pend);
        if (pend) strobe_cnt++;
        if (strobe_cnt >= ORDER) checkOutput("dout", dout, exp_val);
        if (v) acc_cnt++;
        pend = v && (acc_cnt % DECIM == 0);
    endtask

    task automatic runFrames(input logic [7:0] pat, input int plen, input int frames,
                             input int exp_val, input bit gaps);
        int idx = 0;
        while (acc_cnt < frames * DECIM) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 5)) applyStimulus(1'($urandom_range(0, 1)), 1'b0, exp_val);
            end
            applyStimulus(pat[idx], 1'b1, exp_val);
            idx = (idx + 1) % plen;
        end
    endtask

    task automatic runPattern(input string name, input logic [7:0] pat, input int plen,
                              input int frames, input int exp_val, input bit gaps);
        $display("[TB] pattern %s, expecting %0d", name, exp_val);
        resetDut();
        runFrames(pat, plen, frames, exp_val, gaps);
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b1;
        din      = 1'b0;
        repeat (3) begin
            @(negedge clk);
            din = ~din;
        end
        checkOutput("reset_dout", dout, 0);
        checkOutput("reset_valid_out", valid_out, 0);

        runPattern("all_ones", 8'b0000_0001, 1, 4, 32767, 1'b0);
        runPattern("all_zeros", 8'b0000_0000, 1, 4, -32768, 1'b0);
        runPattern("density_1_8", 8'b0000_0001, 8, 5, -24576, 1'b0);
        runPattern("alternating", 8'b0000_0001, 2, 4, 0, 1'b0);
        runPattern("three_of_four", 8'b0000_0111, 4, 4, 16384, 1'b0);

        runPattern("density_1_8_gapped", 8'b0000_0001, 8, 6, -24576, 1'b1);
        repeat (DECIM + 8) applyStimulus(1'($urandom_range(0, 1)), 1'b0, -24576);

        runPattern("all_ones_then_reset", 8'b0000_0001, 1, 3, 32767, 1'b0);
        applyStimulus(1'b1, 1'b1, 32767);
        #20;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_dout", dout, 0);
        checkOutput("async_reset_valid_out", valid_out, 0);
        @(negedge clk);
        valid_in   = 1'b0;
        rst_n      = 1'b1;
        acc_cnt    = 0;
        strobe_cnt = 0;
        pend       = 1'b0;
        runFrames(8'b0000_0001, 8, 4, -24576, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
